// File: rtl/apb_completer_regfile.sv
// APB completer with a bank of DFE filter configuration registers and programmable wait states.
// Optional byte-lane write strobes are enabled by defining APB_PSTRB_EN.
module apb_completer_regfile #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hDFE0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REGS,
  output logic [NUM_REGS-1:0]            REG_WR_PULSE
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned HI_LSB = IDX_W + 2;
  localparam int unsigned CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    write_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    oor_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]     pulse_q;

  logic                    setup_c;
  logic                    access_done;
  logic                    xfer_err;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic                    unused_addr_lsbs;

  // Byte offset within a word plays no part in decode.
  assign unused_addr_lsbs = ^PADDR[1:0];

  assign setup_c = PSEL && !PENABLE;

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_c) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE && (cnt_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and response outputs; read data is forced to zero outside a good read.
  always_comb begin
    access_done = (state_q == ST_WAIT) && PSEL && PENABLE && (cnt_q == '0);
    xfer_err    = oor_q || (write_q && (idx_q == '0));
    PREADY      = access_done;
    PSLVERR     = access_done && xfer_err;
    PRDATA      = '0;
    if (access_done && !write_q && !xfer_err) begin
      PRDATA = rd_word;
    end
  end

  assign rd_word = (idx_q == '0) ? DATA_WIDTH'(ID_VALUE) : regs_q[idx_q];
  assign wr_en   = access_done && write_q && !xfer_err;

  // SETUP-phase capture and wait-state countdown.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
    end else if ((state_q == ST_IDLE) && setup_c) begin
      cnt_q   <= CNT_W'(WAIT_STATES);
      write_q <= PWRITE;
      idx_q   <= PADDR[2 +: IDX_W];
      oor_q   <= |PADDR[ADDR_WIDTH-1:HI_LSB];
      wdata_q <= PWDATA;
    end else if ((state_q == ST_WAIT) && PSEL && PENABLE && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

`ifdef APB_PSTRB_EN
  logic [STRB_W-1:0] strb_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      strb_q <= '0;
    end else if ((state_q == ST_IDLE) && setup_c) begin
      strb_q <= PSTRB;
    end
  end

  // Lanes without a strobe keep their current contents.
  always_comb begin
    wr_word = wdata_q;
    for (int b = 0; b < STRB_W; b++) begin
      if (!strb_q[b]) begin
        wr_word[b*8 +: 8] = regs_q[idx_q][b*8 +: 8];
      end
    end
  end
`else
  assign wr_word = wdata_q;
`endif

  // Register bank and one-cycle write strobes; register 0 is never written.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (wr_en) begin
        regs_q[idx_q]  <= wr_word;
        pulse_q[idx_q] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign REGS[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign REG_WR_PULSE = pulse_q;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile: one instance with 1 wait state, one with 3 for abort checks.
module tb_apb_completer_regfile;

  logic         PCLK;
  logic         PRESET;
  logic         PSEL1, PSEL3;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PADDR;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;

  logic [31:0]  prdata1, prdata3;
  logic         pready1, pready3;
  logic         pslverr1, pslverr3;
  logic [511:0] regs1, regs3;
  logic [15:0]  pulse1, pulse3;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] exp_regs [16];
  logic [31:0] rd;
  logic        err;
  int          nw;

  apb_completer_regfile #(.WAIT_STATES(1)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
    .REGS(regs1), .REG_WR_PULSE(pulse1)
  );

  apb_completer_regfile #(.WAIT_STATES(3)) u_dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .REGS(regs3), .REG_WR_PULSE(pulse3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg1(input int i);
    return regs1[i*32 +: 32];
  endfunction

  function automatic logic [31:0] reg3(input int i);
    return regs3[i*32 +: 32];
  endfunction

  // One SETUP + ACCESS transfer; hold=1 leaves PSEL up so a SETUP can follow immediately.
  task automatic apb_xfer(input bit use3, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold,
                          output logic [31:0] rdata, output logic rerr, output int nwait);
    bit done;
    if (use3) PSEL3 = 1'b1; else PSEL1 = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    nwait = 0;
    done  = 1'b0;
    rdata = '0;
    rerr  = 1'b0;
    while (!done) begin
      @(negedge PCLK);
      if ((use3 ? pready3 : pready1) === 1'b1) begin
        rdata = use3 ? prdata3 : prdata1;
        rerr  = use3 ? pslverr3 : pslverr1;
        done  = 1'b1;
      end else begin
        nwait++;
        if (nwait > 8) begin
          check_eq("xfer_timeout", 32'(nwait), 32'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge PCLK); #1;
    if (!hold) begin
      PSEL1   = 1'b0;
      PSEL3   = 1'b0;
      PENABLE = 1'b0;
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s_r%0d", tag, i), reg1(i), exp_regs[i]);
    end
  endtask

  initial begin
    PRESET = 1'b1; PSEL1 = 1'b0; PSEL3 = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = 4'hF;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Initial reset state
    @(negedge PCLK);
    check_eq("rst0_pready", 32'(pready1), 32'd0);
    check_eq("rst0_pslverr", 32'(pslverr1), 32'd0);
    check_eq("rst0_prdata", prdata1, 32'd0);
    check_eq("rst0_pulse", 32'(pulse1), 32'd0);
    check_all_regs("rst0");

    // Wait-state write to register 2
    apb_xfer(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, rd, err, nw);
    check_eq("ws_write_waits", 32'(nw), 32'd1);
    check_eq("ws_write_err", 32'(err), 32'd0);
    check_eq("ws_write_prdata", rd, 32'd0);
    exp_regs[2] = 32'hDEAD_BEEF;
    @(negedge PCLK);
    check_eq("ws_write_reg2", reg1(2), 32'hDEAD_BEEF);
    check_eq("ws_write_pulse", 32'(pulse1), 32'h0004);
    @(negedge PCLK);
    check_eq("ws_write_pulse_gone", 32'(pulse1), 32'h0000);

    // ID register read and illegal write
    apb_xfer(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rd, err, nw);
    check_eq("id_read_data", rd, 32'hDFE0_0001);
    check_eq("id_read_err", 32'(err), 32'd0);
    apb_xfer(1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, rd, err, nw);
    check_eq("id_write_err", 32'(err), 32'd1);
    check_eq("id_write_prdata", rd, 32'd0);
    @(negedge PCLK);
    check_eq("id_write_pulse", 32'(pulse1), 32'd0);
    apb_xfer(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rd, err, nw);
    check_eq("id_reread_data", rd, 32'hDFE0_0001);

    // Out-of-range read and write
    apb_xfer(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, rd, err, nw);
    check_eq("oor_read_err", 32'(err), 32'd1);
    check_eq("oor_read_data", rd, 32'd0);
    apb_xfer(1'b0, 1'b1, 32'h44, 32'hFFFF_FFFF, 1'b0, rd, err, nw);
    check_eq("oor_write_err", 32'(err), 32'd1);
    @(negedge PCLK);
    check_eq("oor_write_pulse", 32'(pulse1), 32'd0);
    check_all_regs("oor_write");

    // Highest register, and byte-offset bits ignored in decode
    apb_xfer(1'b0, 1'b1, 32'h3C, 32'hCAFE_F00D, 1'b0, rd, err, nw);
    check_eq("top_write_err", 32'(err), 32'd0);
    exp_regs[15] = 32'hCAFE_F00D;
    apb_xfer(1'b0, 1'b0, 32'h3C, 32'h0, 1'b0, rd, err, nw);
    check_eq("top_read_data", rd, 32'hCAFE_F00D);
    apb_xfer(1'b0, 1'b1, 32'h7, 32'h0102_0304, 1'b0, rd, err, nw);
    exp_regs[1] = 32'h0102_0304;
    @(negedge PCLK);
    check_eq("lsb_write_pulse", 32'(pulse1), 32'h0002);
    apb_xfer(1'b0, 1'b0, 32'h4, 32'h0, 1'b0, rd, err, nw);
    check_eq("lsb_read_data", rd, 32'h0102_0304);

    // PENABLE without a preceding SETUP is ignored
    PSEL1 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h9999_9999;
    repeat (3) begin
      @(negedge PCLK);
      check_eq("idle_penable_pready", 32'(pready1), 32'd0);
    end
    @(posedge PCLK); #1;
    PSEL1 = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_eq("idle_penable_pulse", 32'(pulse1), 32'd0);
    check_all_regs("idle_penable");

    // Back-to-back write then read of register 3
    apb_xfer(1'b0, 1'b1, 32'hC, 32'hA5A5_A5A5, 1'b1, rd, err, nw);
    exp_regs[3] = 32'hA5A5_A5A5;
    apb_xfer(1'b0, 1'b0, 32'hC, 32'h0, 1'b0, rd, err, nw);
    check_eq("b2b_read_data", rd, 32'hA5A5_A5A5);
    check_eq("b2b_read_waits", 32'(nw), 32'd1);

    // Abort on the 3-wait-state instance in the 2nd ACCESS cycle
    PSEL3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h5555_AAAA;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check_eq("abort_access1_pready", 32'(pready3), 32'd0);
    @(posedge PCLK); #1;
    PSEL3 = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    @(negedge PCLK);
    check_eq("abort_reg3", reg3(3), 32'd0);
    check_eq("abort_pulse", 32'(pulse3), 32'd0);
    check_eq("abort_pready", 32'(pready3), 32'd0);
    apb_xfer(1'b1, 1'b1, 32'hC, 32'h0BAD_F00D, 1'b0, rd, err, nw);
    check_eq("post_abort_waits", 32'(nw), 32'd3);
    check_eq("post_abort_err", 32'(err), 32'd0);
    @(negedge PCLK);
    check_eq("post_abort_reg3", reg3(3), 32'h0BAD_F00D);
    check_eq("post_abort_pulse", 32'(pulse3), 32'h0008);

`ifdef APB_PSTRB_EN
    // Byte-lane strobes
    apb_xfer(1'b0, 1'b1, 32'h4, 32'h1122_3344, 1'b0, rd, err, nw);
    PSTRB = 4'b0101;
    apb_xfer(1'b0, 1'b1, 32'h4, 32'hAABB_CCDD, 1'b0, rd, err, nw);
    @(negedge PCLK);
    check_eq("strb_reg1", reg1(1), 32'h11BB_33DD);
    PSTRB = 4'b0000;
    apb_xfer(1'b0, 1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0, rd, err, nw);
    @(negedge PCLK);
    check_eq("strb_zero_pulse", 32'(pulse1), 32'h0002);
    check_eq("strb_zero_reg1", reg1(1), 32'h11BB_33DD);
    PSTRB = 4'hF;
    exp_regs[1] = 32'h11BB_33DD;
`endif

    // Reset pulse in the completing ACCESS cycle drops the write
    PSEL1 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h7777_7777;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL1 = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_eq("midrst_pready", 32'(pready1), 32'd0);
    check_eq("midrst_pulse", 32'(pulse1), 32'd0);
    check_eq("midrst_reg4", reg1(4), 32'd0);
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;

    // Traffic, then reset held for two cycles
    apb_xfer(1'b0, 1'b1, 32'h14, 32'h1357_9BDF, 1'b0, rd, err, nw);
    apb_xfer(1'b0, 1'b1, 32'h18, 32'h2468_ACE0, 1'b1, rd, err, nw);
    apb_xfer(1'b1, 1'b1, 32'h8, 32'h0F0F_0F0F, 1'b0, rd, err, nw);
    @(negedge PCLK);
    check_eq("traffic_reg5", reg1(5), 32'h1357_9BDF);
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rst_pready", 32'(pready1), 32'd0);
    check_eq("rst_pslverr", 32'(pslverr1), 32'd0);
    check_eq("rst_prdata", prdata1, 32'd0);
    check_eq("rst_pulse", 32'(pulse1), 32'd0);
    check_all_regs("rst");
    check_eq("rst_dut3_reg2", reg3(2), 32'd0);
    check_eq("rst_dut3_reg3", reg3(3), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    apb_xfer(1'b0, 1'b0, 32'h14, 32'h0, 1'b0, rd, err, nw);
    check_eq("post_rst_read5", rd, 32'd0);
    check_eq("post_rst_waits", 32'(nw), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
